// File: rtl/hex_pkg.sv
// Shared constants and types for the multiplexed hex display controller.
// Holds the scan index width, reset defaults and the reference glyph patterns
// (active-low, bit order {g,f,e,d,c,b,a}).
package hex_pkg;

    localparam int unsigned IDX_W          = 3;
    localparam int unsigned NIB_W          = 4;
    localparam int unsigned SEG_W          = 7;
    localparam int unsigned DEF_NUM_DIGITS = 6;
    localparam int unsigned DEF_SCAN_DIV   = 50000;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_0   = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_1   = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_8   = 7'h00;

    // One register-file entry: the nibble and whether the digit is dark.
    typedef struct packed {
        logic             blank;
        logic [NIB_W-1:0] nibble;
    } digit_t;

    localparam digit_t DIGIT_RESET = '{blank: 1'b1, nibble: 4'h0};

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Bus between user logic and the scan controller.
//   wr_en/wr_addr/wr_data/wr_blank : digit register write port (master -> slave)
//   hex_seg/scan_idx/frame_done    : display outputs (slave -> master)
interface hex_scan_ctrl_if
    import hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS
) ();

    logic                        wr_en;
    logic [IDX_W-1:0]            wr_addr;
    logic [NIB_W-1:0]            wr_data;
    logic                        wr_blank;
    logic [SEG_W*NUM_DIGITS-1:0] hex_seg;
    logic [IDX_W-1:0]            scan_idx;
    logic                        frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, wr_blank,
        input  hex_seg, scan_idx, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_blank,
        output hex_seg, scan_idx, frame_done
    );

endinterface

// File: rtl/hexdisp.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
//   x3..x0 : hex nibble (x3 = MSB)
//   s6..s0 : segments {g,f,e,d,c,b,a}, 0 = segment lit
module hexdisp
    import hex_pkg::*;
(
    input  logic x3,
    input  logic x2,
    input  logic x1,
    input  logic x0,
    output logic s6,
    output logic s5,
    output logic s4,
    output logic s3,
    output logic s2,
    output logic s1,
    output logic s0
);

    logic [NIB_W-1:0] x_c;
    logic [SEG_W-1:0] seg_c;

    assign x_c = {x3, x2, x1, x0};

    // Glyph lookup
    always_comb begin
        seg_c = SEG_BLANK;
        case (x_c)
            4'h0: seg_c = GLYPH_0;
            4'h1: seg_c = GLYPH_1;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = GLYPH_8;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = SEG_BLANK;
        endcase
    end

    assign {s6, s5, s4, s3, s2, s1, s0} = seg_c;

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display controller: one shared decoder serves
// NUM_DIGITS digits, refreshing one digit per prescaled scan tick.
//   clk, resetn : clock and synchronous active-low reset
//   bus (slave) : write port for the digit register file; registered
//                 segment bus, scan index and end-of-frame pulse
module hex_scan_ctrl
    import hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV
) (
    input  logic            clk,
    input  logic            resetn,
    hex_scan_ctrl_if.slave  bus
);

    localparam int unsigned DEPTH    = 1 << IDX_W;
    localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned PRE_LAST = SCAN_DIV - 1;
    localparam int unsigned LAST_IDX = NUM_DIGITS - 1;

    digit_t           regs_q [DEPTH];
    digit_t           regs_d [DEPTH];
    logic [SEG_W-1:0] seg_q  [NUM_DIGITS];
    logic [SEG_W-1:0] seg_d  [NUM_DIGITS];
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fd_q, fd_d;

    digit_t           cur_c;
    logic [SEG_W-1:0] dec_c;

    // Register file is sized to the full index space so the scan read never
    // leaves the array; entries at or above NUM_DIGITS are never written.
    assign cur_c = regs_q[idx_q];

    hexdisp u_dec (
        .x3 (cur_c.nibble[3]),
        .x2 (cur_c.nibble[2]),
        .x1 (cur_c.nibble[1]),
        .x0 (cur_c.nibble[0]),
        .s6 (dec_c[6]),
        .s5 (dec_c[5]),
        .s4 (dec_c[4]),
        .s3 (dec_c[3]),
        .s2 (dec_c[2]),
        .s1 (dec_c[1]),
        .s0 (dec_c[0])
    );

    // Next-state: prescaler, scan step, segment latch and register writes
    always_comb begin
        regs_d = regs_q;
        seg_d  = seg_q;
        pre_d  = (pre_q == PRE_W'(PRE_LAST)) ? '0 : pre_q + PRE_W'(1);
        tick_d = (pre_q == PRE_W'(PRE_LAST));
        idx_d  = idx_q;
        fd_d   = 1'b0;

        // Refresh reads regs_q, so a same-edge write lands after this frame.
        if (tick_q) begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                if (idx_q == IDX_W'(k)) begin
                    seg_d[k] = cur_c.blank ? SEG_BLANK : dec_c;
                end
            end
            fd_d  = (idx_q == IDX_W'(LAST_IDX));
            idx_d = fd_d ? '0 : idx_q + IDX_W'(1);
        end

        if (bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS)) begin
            regs_d[bus.wr_addr] = '{blank: bus.wr_blank, nibble: bus.wr_data};
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                regs_q[k] <= DIGIT_RESET;
            end
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                seg_q[k] <= SEG_BLANK;
            end
            pre_q  <= '0;
            tick_q <= 1'b0;
            idx_q  <= '0;
            fd_q   <= 1'b0;
        end else begin
            regs_q <= regs_d;
            seg_q  <= seg_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
            idx_q  <= idx_d;
            fd_q   <= fd_d;
        end
    end

    // Pack per-digit segment registers onto the output bus
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        assign bus.hex_seg[SEG_W*g +: SEG_W] = seg_q[g];
    end

    assign bus.scan_idx   = idx_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: reference model driven by frame arithmetic,
// a table of write/readback vectors, directed corner cases and random traffic.
module tb_hex_scan_ctrl;
    import hex_pkg::*;

    localparam int unsigned N = 6;
    localparam int unsigned D = 4;
    localparam logic [41:0] ALL_DARK = 42'h3FF_FFFF_FFFF;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic resetn4;
    logic resetn1;

    always #5 clk = ~clk;

    hex_scan_ctrl_if #(.NUM_DIGITS(N)) bus4 ();
    hex_scan_ctrl_if #(.NUM_DIGITS(N)) bus1 ();

    hex_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut4 (
        .clk    (clk),
        .resetn (resetn4),
        .bus    (bus4.slave)
    );

    hex_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(1)) dut1 (
        .clk    (clk),
        .resetn (resetn1),
        .bus    (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: m = edges since reset; refresh count follows from m.
    int         m;
    logic [3:0] mnib [8];
    logic       mblk [8];
    logic [6:0] mseg [N];
    logic [2:0] midx;
    logic       mfd;

    function automatic int nref(input int mm);
        return (mm < 1) ? 0 : (mm - 1) / int'(D);
    endfunction

    function automatic logic [41:0] mpack();
        logic [41:0] p;
        for (int k = 0; k < int'(N); k++) p[7*k +: 7] = mseg[k];
        return p;
    endfunction

    task automatic model_edge();
        int r;
        int p;
        int k;
        if (!resetn4) begin
            m = 0;
            for (int i = 0; i < 8; i++) begin
                mnib[i] = 4'h0;
                mblk[i] = 1'b1;
            end
            for (int i = 0; i < int'(N); i++) mseg[i] = 7'h7F;
            midx = 3'd0;
            mfd  = 1'b0;
        end else begin
            m   = m + 1;
            r   = nref(m);
            p   = nref(m - 1);
            mfd = 1'b0;
            if (r != p) begin
                k       = (r - 1) % int'(N);
                mseg[k] = mblk[k] ? 7'h7F : GLYPH[mnib[k]];
                mfd     = (k == int'(N) - 1);
            end
            midx = 3'(r % int'(N));
            if (bus4.wr_en && (int'(bus4.wr_addr) < int'(N))) begin
                mnib[bus4.wr_addr] = bus4.wr_data;
                mblk[bus4.wr_addr] = bus4.wr_blank;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_seg", 64'(bus4.hex_seg), 64'(mpack()));
        check("model_idx", 64'(bus4.scan_idx), 64'(midx));
        check("model_fd", 64'(bus4.frame_done), 64'(mfd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic b);
        bus4.wr_en    = 1'b1;
        bus4.wr_addr  = a;
        bus4.wr_data  = d;
        bus4.wr_blank = b;
        cyc();
        bus4.wr_en    = 1'b0;
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [3:0] data;
        logic       blank;
        int         chk;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int   last_fd;
        int   last_step;
        int   pulses;
        int   tmo;
        logic [2:0] prev_idx;

        tbl[0] = '{3'd0, 4'h0, 1'b0, 0, 7'h40};
        tbl[1] = '{3'd1, 4'h1, 1'b0, 1, 7'h79};
        tbl[2] = '{3'd5, 4'h8, 1'b0, 5, 7'h00};
        tbl[3] = '{3'd6, 4'h0, 1'b0, 2, 7'h7F};
        tbl[4] = '{3'd7, 4'h0, 1'b0, 3, 7'h7F};
        tbl[5] = '{3'd3, 4'hA, 1'b0, 3, 7'h08};
        tbl[6] = '{3'd4, 4'hF, 1'b0, 4, 7'h0E};
        tbl[7] = '{3'd0, 4'h3, 1'b1, 0, 7'h7F};
        tbl[8] = '{3'd2, 4'h1, 1'b0, 2, 7'h79};

        resetn4 = 1'b0;
        resetn1 = 1'b0;
        bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0; bus4.wr_blank = 1'b0;
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_blank = 1'b0;

        // Reset state, then three idle frames stay dark
        run(2);
        check("rst_seg", 64'(bus4.hex_seg), 64'(ALL_DARK));
        check("rst_idx", 64'(bus4.scan_idx), 64'd0);
        check("rst_fd", 64'(bus4.frame_done), 64'd0);
        resetn4 = 1'b1;
        run(4 + 3 * 24);
        check("idle_dark", 64'(bus4.hex_seg), 64'(ALL_DARK));

        // Table: write one digit, wait out the worst-case latency, read back
        for (int v = 0; v < 9; v++) begin
            wr(tbl[v].addr, tbl[v].data, tbl[v].blank);
            run(int'(N * D) + 1);
            check($sformatf("tbl%0d_dig%0d", v, tbl[v].chk),
                  64'(bus4.hex_seg[7*tbl[v].chk +: 7]), 64'(tbl[v].exp));
            if (v == 2)
                check("basic_frame", 64'(bus4.hex_seg),
                      64'({7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}));
        end

        // Collision: write digit2 on the edge that refreshes it
        tmo = 1;
        for (int i = 0; i < 40; i++) begin
            if ((nref(m + 1) != nref(m)) && ((nref(m + 1) - 1) % int'(N) == 2)) begin
                tmo = 0;
                break;
            end
            cyc();
        end
        check("coll_found", 64'(tmo), 64'd0);
        wr(3'd2, 4'h8, 1'b0);
        check("coll_old", 64'(bus4.hex_seg[20:14]), 64'h79);
        run(23);
        check("coll_hold", 64'(bus4.hex_seg[20:14]), 64'h79);
        cyc();
        check("coll_new", 64'(bus4.hex_seg[20:14]), 64'h00);

        // Cadence over three frames
        last_fd = -1; last_step = -1; pulses = 0;
        prev_idx = bus4.scan_idx;
        for (int i = 0; i < 72; i++) begin
            cyc();
            if (bus4.frame_done) begin
                if (last_fd >= 0) check("fd_gap", 64'(i - last_fd), 64'd24);
                last_fd = i;
                pulses++;
            end
            if (bus4.scan_idx != prev_idx) begin
                check("idx_next", 64'(bus4.scan_idx), 64'((prev_idx == 3'd5) ? 3'd0 : prev_idx + 3'd1));
                if (last_step >= 0) check("idx_gap", 64'(i - last_step), 64'd4);
                last_step = i;
                prev_idx  = bus4.scan_idx;
            end
        end
        check("fd_pulses", 64'(pulses), 64'd3);

        // Random traffic against the model, including rare resets
        for (int i = 0; i < 400; i++) begin
            bus4.wr_en    = ($urandom_range(0, 2) == 0);
            bus4.wr_addr  = 3'($urandom_range(0, 7));
            bus4.wr_data  = 4'($urandom_range(0, 15));
            bus4.wr_blank = ($urandom_range(0, 3) == 0);
            resetn4       = ($urandom_range(0, 99) != 0);
            cyc();
        end
        bus4.wr_en = 1'b0;
        resetn4    = 1'b1;
        run(30);

        // Reset mid-frame at scan index 3
        tmo = 1;
        for (int i = 0; i < 40; i++) begin
            if (midx == 3'd3) begin
                tmo = 0;
                break;
            end
            cyc();
        end
        check("mid_found", 64'(tmo), 64'd0);
        resetn4 = 1'b0;
        cyc();
        check("mid_rst_seg", 64'(bus4.hex_seg), 64'(ALL_DARK));
        check("mid_rst_idx", 64'(bus4.scan_idx), 64'd0);
        resetn4 = 1'b1;
        run(10);

        // SCAN_DIV=1 instance: tick every cycle, six-cycle frame
        check("d1_rst_seg", 64'(bus1.hex_seg), 64'(ALL_DARK));
        check("d1_rst_idx", 64'(bus1.scan_idx), 64'd0);
        resetn1 = 1'b1;
        for (int mm = 1; mm <= 13; mm++) begin
            cyc();
            check($sformatf("d1_idx_%0d", mm), 64'(bus1.scan_idx), 64'((mm - 1) % 6));
            check($sformatf("d1_fd_%0d", mm), 64'(bus1.frame_done),
                  64'((mm > 1) && ((mm - 1) % 6 == 0)));
        end
        check("d1_dark", 64'(bus1.hex_seg), 64'(ALL_DARK));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
